// File: rtl/iwdg_pkg.sv
// Shared definitions for the IWDG sequencer: Wishbone keys, register offsets, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package iwdg_pkg;

    // Keys written to KR
    localparam logic [15:0] ACCESS_KEY = 16'h5555;  // unlock PR/RLR for writing
    localparam logic [15:0] RELOAD_KEY = 16'hAAAA;  // refresh the down-counter
    localparam logic [15:0] COUNT_KEY  = 16'hCCCC;  // start the watchdog

    // Register byte offsets from the IWDG base address
    localparam logic [31:0] KR_OFS  = 32'h0000_0000;
    localparam logic [31:0] PR_OFS  = 32'h0000_0004;
    localparam logic [31:0] RLR_OFS = 32'h0000_0008;
    localparam logic [31:0] ST_OFS  = 32'h0000_000C;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_UNLOCK  = 4'd1,
        ST_WR_PR   = 4'd2,
        ST_WR_RLR  = 4'd3,
        ST_VERIFY  = 4'd4,
        ST_START   = 4'd5,
        ST_RUNNING = 4'd6,
        ST_KICK    = 4'd7,
        ST_ERROR   = 4'd8
    } iwdg_state_e;

endpackage

// File: rtl/iwdg_wb_master.sv
// Single-transaction Wishbone master: one classic cycle per accepted req, with ack timeout.
// Latency: cyc/stb rise the cycle after req is seen while idle; done/timeout are same-cycle with ack/expiry.
// Backpressure: holds cyc/stb/adr/dat/we stable until ack or ACK_TIMEOUT cycles; req ignored while a cycle is open.
//
// Ports: clk_m2s/rst_m2s clock and async active-low reset; req/we/adr/wdat transaction request;
// done/rdat/timeout completion status; adr/dat/we/cyc/stb_m2s and dat/ack_s2m the Wishbone bus.
module iwdg_wb_master #(
    parameter int KR_SIZE     = 16,
    parameter int ACK_TIMEOUT = 32
) (
    input  logic               clk_m2s,
    input  logic               rst_m2s,
    // request side
    input  logic               req,
    input  logic               we,
    input  logic [31:0]        adr,
    input  logic [KR_SIZE-1:0] wdat,
    output logic               done,
    output logic [KR_SIZE-1:0] rdat,
    output logic               timeout,
    // Wishbone side
    output logic [31:0]        adr_m2s,
    output logic [KR_SIZE-1:0] dat_m2s,
    output logic               we_m2s,
    output logic               cyc_m2s,
    output logic               stb_m2s,
    input  logic [KR_SIZE-1:0] dat_s2m,
    input  logic               ack_s2m
);

    localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    // Last cycle number (0-based) that cyc may stay open without an ack
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    logic [31:0]        adr_q, adr_d;
    logic [KR_SIZE-1:0] dat_q, dat_d;
    logic               we_q, we_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;

    // Completion is combinational so the FSM can advance on the same edge
    // that drops cyc; this keeps a zero-wait write at three cycles.
    assign done    = cyc_q & ack_s2m;
    assign timeout = cyc_q & ~ack_s2m & (tcnt_q == TO_LAST);
    assign rdat    = dat_s2m;

    always_comb begin
        adr_d  = adr_q;
        dat_d  = dat_q;
        we_d   = we_q;
        cyc_d  = cyc_q;
        stb_d  = stb_q;
        tcnt_d = tcnt_q;
        if (cyc_q) begin
            if (done || timeout) begin
                cyc_d  = 1'b0;
                stb_d  = 1'b0;
                tcnt_d = '0;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end else if (req) begin
            cyc_d  = 1'b1;
            stb_d  = 1'b1;
            we_d   = we;
            adr_d  = adr;
            dat_d  = wdat;
            tcnt_d = '0;
        end
    end

    always_ff @(posedge clk_m2s or negedge rst_m2s) begin
        if (!rst_m2s) begin
            adr_q  <= '0;
            dat_q  <= '0;
            we_q   <= 1'b0;
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            tcnt_q <= '0;
        end else begin
            adr_q  <= adr_d;
            dat_q  <= dat_d;
            we_q   <= we_d;
            cyc_q  <= cyc_d;
            stb_q  <= stb_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign adr_m2s = adr_q;
    assign dat_m2s = dat_q;
    assign we_m2s  = we_q;
    assign cyc_m2s = cyc_q;
    assign stb_m2s = stb_q;

endmodule

// File: rtl/iwdg_seq_ctrl.sv
// IWDG sequencer: unlocks, programs PR/RLR, starts the watchdog, then refreshes it periodically or on demand.
// Latency: start to cfg_done is 13 cycles with a zero-wait slave (16 with IWDG_SEQ_VERIFY_EN); kick_req to cyc is 2 cycles.
// Backpressure: each bus step waits for ack (bounded by ACK_TIMEOUT, then ERROR); start while busy is ignored.
//
// Ports: clk_m2s/rst_m2s clock and async active-low reset; start/stop/kick_req control pulses;
// cfg_pr/cfg_rlr/kick_period configuration; Wishbone master bus (*_m2s out, *_s2m in); busy/cfg_done/err status.
// Optional build macro IWDG_SEQ_VERIFY_EN adds a read-back check of RLR before the watchdog is started.
module iwdg_seq_ctrl
    import iwdg_pkg::*;
#(
    parameter int          IWDG_KR_SIZE  = 16,
    parameter int          IWDG_PR_SIZE  = 3,
    parameter int          IWDG_RLR_SIZE = 12,
    parameter logic [31:0] BASE_ADR      = 32'h0100_0000,
    parameter int          KICK_CNT_SIZE = 16,
    parameter int          ACK_TIMEOUT   = 32
) (
    input  logic                     clk_m2s,
    input  logic                     rst_m2s,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     kick_req,
    input  logic [IWDG_PR_SIZE-1:0]  cfg_pr,
    input  logic [IWDG_RLR_SIZE-1:0] cfg_rlr,
    input  logic [KICK_CNT_SIZE-1:0] kick_period,
    output logic [31:0]              adr_m2s,
    output logic [IWDG_KR_SIZE-1:0]  dat_m2s,
    output logic                     we_m2s,
    output logic                     cyc_m2s,
    output logic                     stb_m2s,
    input  logic [IWDG_KR_SIZE-1:0]  dat_s2m,
    input  logic                     ack_s2m,
    output logic                     busy,
    output logic                     cfg_done,
    output logic                     err
);

    localparam logic [KICK_CNT_SIZE-1:0] KCNT_ONE = KICK_CNT_SIZE'(1);

    iwdg_state_e                state_q, state_d;
    logic [IWDG_PR_SIZE-1:0]    pr_q, pr_d;
    logic [IWDG_RLR_SIZE-1:0]   rlr_q, rlr_d;
    logic [KICK_CNT_SIZE-1:0]   kcnt_q, kcnt_d;
    logic                       stop_pend_q, stop_pend_d;
    logic                       busy_q, busy_d;
    logic                       cfg_done_q, cfg_done_d;
    logic                       err_q, err_d;

    logic                       bus_req;
    logic                       bus_we;
    logic [31:0]                bus_adr;
    logic [IWDG_KR_SIZE-1:0]    bus_wdat;
    logic                       bus_done;
    logic                       bus_timeout;
    logic [IWDG_KR_SIZE-1:0]    bus_rdat;
    logic [KICK_CNT_SIZE-1:0]   kload;

    // A zero period would never expire; run it as one cycle instead.
    assign kload = (kick_period == '0) ? KCNT_ONE : kick_period;

    // Transaction requested by each bus state. The master only samples
    // this while idle, so holding it through the open cycle is harmless.
    always_comb begin
        bus_req  = 1'b0;
        bus_we   = 1'b1;
        bus_adr  = BASE_ADR + KR_OFS;
        bus_wdat = '0;
        case (state_q)
            ST_UNLOCK: begin
                bus_req  = 1'b1;
                bus_wdat = IWDG_KR_SIZE'(ACCESS_KEY);
            end
            ST_WR_PR: begin
                bus_req  = 1'b1;
                bus_adr  = BASE_ADR + PR_OFS;
                bus_wdat = IWDG_KR_SIZE'(pr_q);
            end
            ST_WR_RLR: begin
                bus_req  = 1'b1;
                bus_adr  = BASE_ADR + RLR_OFS;
                bus_wdat = IWDG_KR_SIZE'(rlr_q);
            end
`ifdef IWDG_SEQ_VERIFY_EN
            ST_VERIFY: begin
                bus_req  = 1'b1;
                bus_we   = 1'b0;
                bus_adr  = BASE_ADR + RLR_OFS;
            end
`endif
            ST_START: begin
                bus_req  = 1'b1;
                bus_wdat = IWDG_KR_SIZE'(COUNT_KEY);
            end
            ST_KICK: begin
                bus_req  = 1'b1;
                bus_wdat = IWDG_KR_SIZE'(RELOAD_KEY);
            end
            default: begin
                bus_req  = 1'b0;
            end
        endcase
    end

`ifdef IWDG_SEQ_VERIFY_EN
    logic rlr_mismatch;
    assign rlr_mismatch = (bus_rdat[IWDG_RLR_SIZE-1:0] != rlr_q);
`else
    // Read data is only consumed by the verify step.
    logic unused_rdat;
    assign unused_rdat = ^bus_rdat;
`endif

    always_comb begin
        state_d     = state_q;
        pr_d        = pr_q;
        rlr_d       = rlr_q;
        kcnt_d      = kcnt_q;
        stop_pend_d = stop_pend_q;
        cfg_done_d  = cfg_done_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (start) begin
                    pr_d        = cfg_pr;
                    rlr_d       = cfg_rlr;
                    err_d       = 1'b0;
                    cfg_done_d  = 1'b0;
                    stop_pend_d = 1'b0;
                    state_d     = ST_UNLOCK;
                end else if (stop) begin
                    cfg_done_d  = 1'b0;
                end
            end
            ST_RUNNING: begin
                // stop beats kick_req beats counter expiry
                if (stop) begin
                    cfg_done_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (kick_req || (kcnt_q == KCNT_ONE)) begin
                    state_d    = ST_KICK;
                end else begin
                    kcnt_d     = kcnt_q - 1'b1;
                end
            end
            ST_UNLOCK, ST_WR_PR, ST_WR_RLR, ST_START, ST_KICK
`ifdef IWDG_SEQ_VERIFY_EN
            , ST_VERIFY
`endif
            : begin
                // A stop here lets the open transaction finish first.
                if (stop) begin
                    stop_pend_d = 1'b1;
                    cfg_done_d  = 1'b0;
                end
                if (bus_timeout) begin
                    err_d       = 1'b1;
                    stop_pend_d = 1'b0;
                    state_d     = ST_ERROR;
                end else if (bus_done) begin
                    if (stop || stop_pend_q) begin
                        stop_pend_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        case (state_q)
                            ST_UNLOCK: state_d = ST_WR_PR;
                            ST_WR_PR:  state_d = ST_WR_RLR;
`ifdef IWDG_SEQ_VERIFY_EN
                            ST_WR_RLR: state_d = ST_VERIFY;
                            ST_VERIFY: begin
                                if (rlr_mismatch) begin
                                    err_d   = 1'b1;
                                    state_d = ST_ERROR;
                                end else begin
                                    state_d = ST_START;
                                end
                            end
`else
                            ST_WR_RLR: state_d = ST_START;
`endif
                            ST_START: begin
                                cfg_done_d = 1'b1;
                                state_d    = ST_RUNNING;
                            end
                            ST_KICK:   state_d = ST_RUNNING;
                            default:   state_d = ST_IDLE;
                        endcase
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Every entry into RUNNING (after START or KICK) restarts the interval.
        if ((state_d == ST_RUNNING) && (state_q != ST_RUNNING)) begin
            kcnt_d = kload;
        end
        busy_d = (state_d != ST_IDLE) && (state_d != ST_ERROR);
    end

    always_ff @(posedge clk_m2s or negedge rst_m2s) begin
        if (!rst_m2s) begin
            state_q     <= ST_IDLE;
            pr_q        <= '0;
            rlr_q       <= '0;
            kcnt_q      <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            cfg_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pr_q        <= pr_d;
            rlr_q       <= rlr_d;
            kcnt_q      <= kcnt_d;
            stop_pend_q <= stop_pend_d;
            busy_q      <= busy_d;
            cfg_done_q  <= cfg_done_d;
            err_q       <= err_d;
        end
    end

    assign busy     = busy_q;
    assign cfg_done = cfg_done_q;
    assign err      = err_q;

    iwdg_wb_master #(
        .KR_SIZE     (IWDG_KR_SIZE),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_wb_master (
        .clk_m2s (clk_m2s),
        .rst_m2s (rst_m2s),
        .req     (bus_req),
        .we      (bus_we),
        .adr     (bus_adr),
        .wdat    (bus_wdat),
        .done    (bus_done),
        .rdat    (bus_rdat),
        .timeout (bus_timeout),
        .adr_m2s (adr_m2s),
        .dat_m2s (dat_m2s),
        .we_m2s  (we_m2s),
        .cyc_m2s (cyc_m2s),
        .stb_m2s (stb_m2s),
        .dat_s2m (dat_s2m),
        .ack_s2m (ack_s2m)
    );

endmodule

// File: doc/iwdg_seq_ctrl.md
# iwdg_seq_ctrl

Wishbone master that configures and services the IWDG watchdog block. On a start pulse it unlocks the IWDG with the access key, programs PR and RLR, and starts the counter. It then refreshes the counter with the reload key at a programmable interval, or on demand, until stopped. It sits between the system control logic and the IWDG Wishbone slave port and is the only master on that port.

## Interface
Parameters:
- IWDG_KR_SIZE, 16, bus data width (KR width)
- IWDG_PR_SIZE, 3, prescaler field width
- IWDG_RLR_SIZE, 12, reload field width
- BASE_ADR, 32'h0100_0000, IWDG base; KR/PR/RLR/ST at +0x0/+0x4/+0x8/+0xC
- KICK_CNT_SIZE, 16, width of kick interval counter
- ACK_TIMEOUT, 32, max cycles waiting for ack_s2m

Ports:
- clk_m2s  in  1  single system clock; all logic on rising edge
- rst_m2s  in  1  asynchronous, active-low reset
- start  in  1  pulse; begin the configuration sequence (accepted in IDLE or ERROR only)
- stop  in  1  pulse; stop kicking, return to IDLE
- kick_req  in  1  pulse; immediate refresh while RUNNING
- cfg_pr  in  IWDG_PR_SIZE  prescaler value, sampled on accepted start
- cfg_rlr  in  IWDG_RLR_SIZE  reload value, sampled on accepted start
- kick_period  in  KICK_CNT_SIZE  cycles between refreshes; 0 is treated as 1
- adr_m2s  out  32  Wishbone address
- dat_m2s  out  IWDG_KR_SIZE  Wishbone write data
- we_m2s, cyc_m2s, stb_m2s  out  1 each  Wishbone controls
- dat_s2m  in  IWDG_KR_SIZE  Wishbone read data
- ack_s2m  in  1  Wishbone acknowledge
- busy  out  1  high outside IDLE/ERROR
- cfg_done  out  1  high once the start write is acknowledged; cleared by start/stop
- err  out  1  sticky; set on timeout or verify mismatch; cleared by an accepted start

## Operation
- States: IDLE, UNLOCK, WR_PR, WR_RLR, VERIFY (macro only), START, RUNNING, KICK, ERROR.
- IDLE/ERROR + start: latch cfg_pr/cfg_rlr, clear err and cfg_done, go to UNLOCK.
- UNLOCK: write 16'h5555 to KR. WR_PR: write the zero-extended cfg_pr to PR. WR_RLR: write the zero-extended cfg_rlr to RLR. START: write 16'hCCCC to KR, then set cfg_done and go to RUNNING.
- RUNNING: the down-counter loads max(kick_period,1) on entry. On reaching 1, or on kick_req, go to KICK. KICK writes 16'hAAAA to KR, then returns to RUNNING and reloads the counter.
- stop: in RUNNING, go to IDLE next cycle. In a bus state, complete or time out the current transaction, then go to IDLE.
- Priority within one cycle: stop > kick_req > counter expiry. kick_req during KICK is dropped.
- Timeout: if ACK_TIMEOUT cycles pass with cyc_m2s high and no ack, drop cyc/stb, set err, go to ERROR. In ERROR no bus activity occurs until start.
- start while busy is ignored.

## Timing
- Reset values: cyc_m2s, stb_m2s, we_m2s = 0; adr_m2s, dat_m2s = 0; busy, cfg_done, err = 0; state IDLE.
- All outputs are registered.
- A transaction drives cyc, stb, adr, dat and we starting the cycle after the state is entered. They are held stable until ack_s2m is sampled high.
- cyc and stb drop on the edge that samples ack. At least one idle cycle with cyc low separates transactions.
- With a zero-wait slave (ack one cycle after stb), each write occupies 3 cycles. start to cfg_done is at most 13 cycles without the macro.
- Reset asserted mid-transaction drops cyc/stb asynchronously.

## Configuration
- IWDG_SEQ_VERIFY_EN defined: after WR_RLR, the VERIFY state performs a read (we=0) of RLR.
  - If dat_s2m[IWDG_RLR_SIZE-1:0] differs from the latched cfg_rlr, set err and go to ERROR.
  - Otherwise go to START.
- Not defined: VERIFY is absent and WR_RLR goes directly to START; the block issues no reads.

## Structure
- Package iwdg_pkg contains:
  - key constants ACCESS_KEY=16'h5555, RELOAD_KEY=16'hAAAA, COUNT_KEY=16'hCCCC
  - register offsets KR/PR/RLR/ST
  - the state enum typedef
- Sub-module iwdg_wb_master: a single-transaction engine.
  - Inputs: req, we, adr, wdat.
  - Outputs: done, rdat, timeout.
  - Owns cyc/stb/we/adr/dat_m2s and the ACK_TIMEOUT counter.
- The top level holds the FSM and the kick counter.

## Test plan
- Reset: hold rst_m2s=0 with random inputs -> all outputs 0; release -> cyc_m2s stays 0 until start.
- Configure: start with cfg_pr=3'b001, cfg_rlr=12'h001 and a 1-wait slave -> writes KR=16'h5555, PR=16'h0001, RLR=16'h0001, KR=16'hCCCC, in order; then cfg_done=1 and err=0.
- Periodic kick: kick_period=8 -> KR=16'hAAAA writes repeat at a fixed interval (8 + transaction cycles); kick_period=0 behaves as 1; kick_req in RUNNING -> an AAAA write starts within 2 cycles.
- Timeout: ACK_TIMEOUT=16 and the slave never acks PR -> cyc_m2s falls after 16 cycles, err=1, busy=0, no further bus cycles; a new start clears err and restarts at UNLOCK.
- Stop: stop during RUNNING -> busy=0 next cycle with no AAAA write; stop mid-write -> that write completes, then IDLE; stop together with kick_req -> no kick.
- Verify (macro on): the slave returns 16'h0002 for the RLR read -> err=1 and no CCCC write. Macro off: no we_m2s=0 cycle appears in the sequence.
